// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank clock-enable/divided-clock generator.
// Divisor and phase clamping live here so every channel coerces values identically.
package clk_div_pkg;

   typedef enum logic [1:0] {
      S_STARTUP,
      S_RUN,
      S_UPDATE
   } state_e;

   localparam int DIV_W_DEFAULT = 16;

   // Divisors below 2 cannot form a high and a low phase, so they run as 2.
   function automatic logic [31:0] clamp_div(input logic [31:0] d);
      return (d < 32'd2) ? 32'd2 : d;
   endfunction

   function automatic logic [31:0] clamp_phase(input logic [31:0] p, input logic [31:0] d);
      return (p >= d) ? (d - 32'd1) : p;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, pending divisor applied at the period boundary,
// registered clk_en/clk_out. Start phase support is built only with `CLKDIV_PHASE_EN.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int               DIV_W   = DIV_W_DEFAULT,
   parameter logic [DIV_W-1:0] RST_DIV = DIV_W'(2)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
`ifdef CLKDIV_PHASE_EN
   input  logic [DIV_W-1:0] i_phase,
`endif
   output logic             o_pending,
   output logic             o_clk_en,
   output logic             o_clk_out
);

   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
   localparam logic [DIV_W-1:0] RST_DIV_C = DIV_W'(clamp_div(32'(RST_DIV)));

   logic [DIV_W-1:0] r_cnt, r_div, r_pend_div;
   logic             r_pend, r_run, r_clk_en, r_clk_out;
   logic [DIV_W-1:0] w_cnt_nxt, w_div_nxt, w_start;
   logic             w_pend_nxt, w_apply, w_boundary;
`ifdef CLKDIV_PHASE_EN
   logic [DIV_W-1:0] r_phase, r_pend_phase, w_phase_nxt;
`endif

   // A boundary is the wrap of a running period or the first cycle after (re)enable;
   // a disabled channel has no period to protect, so it applies a pending divisor at once.
   always_comb begin
      w_div_nxt  = r_div;
      w_pend_nxt = r_pend;
      w_cnt_nxt  = r_cnt + ONE;
      w_apply    = 1'b0;
      w_boundary = 1'b0;
      w_start    = '0;
`ifdef CLKDIV_PHASE_EN
      w_phase_nxt = r_phase;
`endif
      if (!i_en) begin
         w_cnt_nxt = '0;
         w_apply   = r_pend;
      end else if (!r_run || (r_cnt == r_div - ONE)) begin
         w_boundary = 1'b1;
         w_apply    = r_pend;
      end
      if (w_apply) begin
         w_div_nxt  = r_pend_div;
         w_pend_nxt = 1'b0;
`ifdef CLKDIV_PHASE_EN
         w_phase_nxt = r_pend_phase;
`endif
      end
`ifdef CLKDIV_PHASE_EN
      if (w_apply || !r_run)
         w_start = DIV_W'(clamp_phase(32'(w_phase_nxt), 32'(w_div_nxt)));
`endif
      if (w_boundary) w_cnt_nxt = w_start;
      if (i_load) w_pend_nxt = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_div      <= RST_DIV_C;
         r_pend_div <= RST_DIV_C;
         r_pend     <= 1'b0;
         r_run      <= 1'b0;
         r_clk_en   <= 1'b0;
         r_clk_out  <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_div     <= w_div_nxt;
         r_pend    <= w_pend_nxt;
         r_run     <= i_en;
         r_clk_en  <= i_en && (w_cnt_nxt == w_div_nxt - ONE);
         r_clk_out <= i_en && (w_cnt_nxt < (w_div_nxt >> 1));
         if (i_load) r_pend_div <= DIV_W'(clamp_div(32'(i_div)));
      end
   end

`ifdef CLKDIV_PHASE_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_phase      <= '0;
         r_pend_phase <= '0;
      end else begin
         r_phase <= w_phase_nxt;
         if (i_load) r_pend_phase <= i_phase;
      end
   end
`endif

   assign o_pending = r_pend;
   assign o_clk_en  = r_clk_en;
   assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable divider bank with MMCM-style lock and a cfg valid/ready port.
// Optional per-channel start phase (cfg_phase) is enabled by defining `CLKDIV_PHASE_EN.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int                        NUM_CH      = 2,
   parameter int                        DIV_W       = DIV_W_DEFAULT,
   parameter logic [NUM_CH*DIV_W-1:0]   DEFAULT_DIV = {16'd100, 16'd5},
   parameter int                        LOCK_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic [NUM_CH*DIV_W-1:0]   cfg_div,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   output logic [NUM_CH-1:0]         clk_en,
   output logic [NUM_CH-1:0]         clk_out,
`ifdef CLKDIV_PHASE_EN
   input  logic [NUM_CH*DIV_W-1:0]   cfg_phase,
`endif
   output logic                      locked
);

   localparam int            LCW       = $clog2(LOCK_CYCLES + 1);
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

   // Handshake: a cfg word transfers on a rising edge where cfg_valid && cfg_ready;
   // cfg_ready is high only in S_RUN, and a valid seen while it is low is dropped, not queued.
   state_e             r_state, w_state_nxt;
   logic [LCW-1:0]     r_lock_cnt, w_lock_nxt;
   logic               w_load;
   logic [NUM_CH-1:0]  w_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_STARTUP;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock_cnt;
      w_load      = 1'b0;
      cfg_ready   = 1'b0;
      locked      = 1'b0;
      case (r_state)
         S_STARTUP: begin
            if (r_lock_cnt == LOCK_LAST) w_state_nxt = S_RUN;
            else                         w_lock_nxt  = r_lock_cnt + LCW'(1);
         end
         S_RUN: begin
            locked    = 1'b1;
            cfg_ready = 1'b1;
            if (cfg_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            if (~|w_pending) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_STARTUP;
      endcase
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_channel #(
         .DIV_W   (DIV_W),
         .RST_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
      ) u_ch (
         .i_clk     (clk),
         .i_rst     (reset),
         .i_en      (ch_enable[g]),
         .i_load    (w_load),
         .i_div     (cfg_div[g*DIV_W +: DIV_W]),
`ifdef CLKDIV_PHASE_EN
         .i_phase   (cfg_phase[g*DIV_W +: DIV_W]),
`endif
         .o_pending (w_pending[g]),
         .o_clk_en  (clk_en[g]),
         .o_clk_out (clk_out[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: lock timing, periods/duty, runtime reprogramming,
// divisor coercion, channel disable/re-enable and reset during an update.
module tb_clk_div_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ch_enable;
   logic [31:0] cfg_div;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  clk_en;
   logic [1:0]  clk_out;
   logic        locked;
`ifdef CLKDIV_PHASE_EN
   logic [31:0] cfg_phase;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int n, h;

   always #5 clk = ~clk;

   clk_div_bank dut (
      .clk       (clk),
      .reset     (reset),
      .ch_enable (ch_enable),
      .cfg_div   (cfg_div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .clk_en    (clk_en),
      .clk_out   (clk_out),
`ifdef CLKDIV_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .locked    (locked)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", tag);
   endtask

   // Counts cycles (and clk_out-high cycles) up to and including the next clk_en of ch.
   task automatic run_period(input int ch, output int cnt, output int hi);
      cnt = 0;
      hi  = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cnt++;
         if (clk_out[ch]) hi++;
         if (clk_en[ch]) return;
      end
      timeout("period_wait");
   endtask

   task automatic check_period(input string tag, input int ch, input int d);
      int c, x;
      run_period(ch, c, x);
      check({tag, "_len"}, c, d);
      check({tag, "_high"}, x, d / 2);
   endtask

   task automatic lock_after_reset(input string tag);
      repeat (63) @(posedge clk);
      #1 check({tag, "_lock63"}, locked, 1'b0);
      @(posedge clk);
      #1 check({tag, "_lock64"}, locked, 1'b1);
      check({tag, "_ready"}, cfg_ready, 1'b1);
   endtask

   task automatic wait_locked();
      for (int i = 0; i < 400; i++) begin
         if (locked) return;
         @(negedge clk);
      end
      timeout("lock_wait");
   endtask

   task automatic send_cfg(input logic [31:0] div);
      wait_locked();
      cfg_div   = div;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      ch_enable = 2'b11;
      cfg_div   = '0;
      cfg_valid = 1'b0;
`ifdef CLKDIV_PHASE_EN
      cfg_phase = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_clk_en", clk_en, 2'b00);
      check("rst_clk_out", clk_out, 2'b00);
      check("rst_locked", locked, 1'b0);
      check("rst_ready", cfg_ready, 1'b0);
      reset = 1'b0;

      // Defaults: lock 64 cycles after release, ch0 period 5 (2 high), ch1 period 100.
      lock_after_reset("t1");
      run_period(0, n, h);
      check_period("t1_ch0", 0, 5);
      run_period(1, n, h);
      check_period("t1_ch1", 1, 100);

      // Disable ch1 at cnt=37, re-enable 10 cycles later.
      run_period(1, n, h);
      repeat (38) @(negedge clk);
      check("t4_out_at37", clk_out[1], 1'b1);
      ch_enable[1] = 1'b0;
      @(negedge clk);
      check("t4_out_off", clk_out[1], 1'b0);
      repeat (9) @(negedge clk);
      check("t4_off_hold", {clk_en[1], clk_out[1]}, 2'b00);
      ch_enable[1] = 1'b1;
      @(negedge clk);
      check("t4_restart_out", clk_out[1], 1'b1);
      run_period(1, n, h);
      check("t4_rest_len", n, 99);
      check("t4_rest_high", h, 49);

      // Reprogram ch0=8, ch1=3 right at a ch0 boundary; old ch0 period must complete.
      wait_locked();
      run_period(0, n, h);
      cfg_div   = {16'd3, 16'd8};
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
      check("t2_ready_drop", cfg_ready, 1'b0);
      check("t2_unlocked", locked, 1'b0);
      check_period("t2_ch0_old", 0, 5);
      check_period("t2_ch0_new", 0, 8);
      run_period(1, n, h);
      check_period("t2_ch1_new", 1, 3);
      check("t2_relock", locked, 1'b1);

      // Divisors 0 and 1 both coerce to 2.
      send_cfg({16'd1, 16'd0});
      run_period(0, n, h);
      check_period("t3_ch0_d0", 0, 2);
      run_period(1, n, h);
      check_period("t3_ch1_d1", 1, 2);

      // Reset during an update: async clear, defaults restored, relock after 64.
      send_cfg({16'd200, 16'd8});
      check("t5_in_update", locked, 1'b0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check("t5_async_out", {clk_en, clk_out, locked, cfg_ready}, 6'b0);
      @(negedge clk);
      reset = 1'b0;
      lock_after_reset("t5");
      run_period(0, n, h);
      check_period("t5_ch0", 0, 5);
      run_period(1, n, h);
      check_period("t5_ch1", 1, 100);

`ifdef CLKDIV_PHASE_EN
      // Start phase: D=10 P=7 gives a 3-cycle first period; P=12 clamps to 9.
      cfg_phase = {16'd0, 16'd7};
      send_cfg({16'd100, 16'd10});
      run_period(0, n, h);
      run_period(0, n, h);
      check("t6_p7_len", n, 3);
      check_period("t6_p7_next", 0, 10);
      cfg_phase = {16'd0, 16'd12};
      send_cfg({16'd100, 16'd10});
      run_period(0, n, h);
      run_period(0, n, h);
      check("t6_p12_len", n, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

endmodule
